// File: rtl/alu_mdu.sv
// Execute-stage unit: single-cycle ALU ops with registered result, plus an
// iterative shift-add multiplier / restoring divider that owns HI/LO.
module alu_mdu #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [SHW-1:0]   shamt,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic             zero,
    output logic             busy,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] ZERO_W   = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONE_W    = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] ONES_W   = {WIDTH{1'b1}};
    localparam logic [SHW-1:0]   CNT_LAST = SHW'(WIDTH - 1);
    localparam logic [SHW-1:0]   CNT_ONE  = {{(SHW-1){1'b0}}, 1'b1};

    state_t             state_r, state_s;
    logic [SHW-1:0]     cnt_r;
    logic [2*WIDTH-1:0] work_r;
    logic [WIDTH-1:0]   mag_b_r, a_r, y_r, hi_r, lo_r;
    logic               mdiv_r, neg_q_r, neg_r_r, dz_r, zero_r;

    logic               accept_s, is_multi_s, signed_op_s, last_s;
    logic [WIDTH-1:0]   mag_a_s, mag_b_s, alu_s, fin_hi_s, fin_lo_s;
    logic [WIDTH:0]     mul_sum_s, div_shift_s, div_diff_s;
    logic [2*WIDTH-1:0] mul_next_s, div_next_s, next_work_s;

    assign in_ready    = (state_r == ST_IDLE) || ((state_r == ST_DONE) && out_ready);
    assign out_valid   = (state_r == ST_DONE);
    assign busy        = (state_r == ST_BUSY);
    assign y           = y_r;
    assign zero        = zero_r;
    assign hi          = hi_r;
    assign lo          = lo_r;

    assign accept_s    = in_valid && in_ready;
    assign is_multi_s  = (op[4:2] == 3'b011);
    assign signed_op_s = ~op[0];
    assign last_s      = (cnt_r == CNT_LAST);
    assign mag_a_s     = (signed_op_s && a[WIDTH-1]) ? -a : a;
    assign mag_b_s     = (signed_op_s && b[WIDTH-1]) ? -b : b;

    // Multiply step: add multiplicand into the upper half when LSB set, then shift right.
    assign mul_sum_s   = {1'b0, work_r[2*WIDTH-1:WIDTH]}
                       + {1'b0, (work_r[0] ? mag_b_r : ZERO_W)};
    assign mul_next_s  = {mul_sum_s, work_r[WIDTH-1:1]};

    // Restoring divide step: upper half is the partial remainder, lower half shifts
    // dividend bits out and quotient bits in.
    assign div_shift_s = {work_r[2*WIDTH-1:WIDTH], work_r[WIDTH-1]};
    assign div_diff_s  = div_shift_s - {1'b0, mag_b_r};
    assign div_next_s  = div_diff_s[WIDTH]
                       ? {div_shift_s[WIDTH-1:0], work_r[WIDTH-2:0], 1'b0}
                       : {div_diff_s[WIDTH-1:0],  work_r[WIDTH-2:0], 1'b1};
    assign next_work_s = mdiv_r ? div_next_s : mul_next_s;

    // Single-cycle result selection.
    always_comb begin
        alu_s = ZERO_W;
        case (op)
            5'b00000: alu_s = a & b;
            5'b00001: alu_s = a | b;
            5'b00010: alu_s = a + b;
            5'b00011: alu_s = b << shamt;
            5'b00100: alu_s = a + ~b;
            5'b00101: alu_s = a | ~b;
            5'b00110: alu_s = a - b;
            5'b00111: alu_s = ($signed(a) < $signed(b)) ? ONE_W : ZERO_W;
            5'b01000: alu_s = b << (WIDTH / 2);
            5'b01001: alu_s = a ^ b;
            5'b01010: alu_s = ($signed(a) <= $signed(ZERO_W)) ? ZERO_W : ONE_W;
            5'b01011: alu_s = a >> b[SHW-1:0];
            5'b10000: alu_s = hi_r;
            5'b10001: alu_s = lo_r;
            5'b10010: alu_s = a;
            5'b10011: alu_s = a;
            default:  alu_s = ZERO_W;
        endcase
    end

    // Sign fix-up of the final iteration; divide by zero bypasses the datapath.
    always_comb begin
        fin_hi_s = next_work_s[2*WIDTH-1:WIDTH];
        fin_lo_s = next_work_s[WIDTH-1:0];
        if (mdiv_r) begin
            if (dz_r) begin
                fin_hi_s = a_r;
                fin_lo_s = ONES_W;
            end else begin
                if (neg_q_r) begin
                    fin_lo_s = -next_work_s[WIDTH-1:0];
                end else begin
                    fin_lo_s = next_work_s[WIDTH-1:0];
                end
                if (neg_r_r) begin
                    fin_hi_s = -next_work_s[2*WIDTH-1:WIDTH];
                end else begin
                    fin_hi_s = next_work_s[2*WIDTH-1:WIDTH];
                end
            end
        end else begin
            if (neg_q_r) begin
                {fin_hi_s, fin_lo_s} = -next_work_s;
            end else begin
                {fin_hi_s, fin_lo_s} = next_work_s;
            end
        end
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_s = is_multi_s ? ST_BUSY : ST_DONE;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (last_s) begin
                    state_s = ST_DONE;
                end else begin
                    state_s = ST_BUSY;
                end
            end
            ST_DONE: begin
                if (!out_ready) begin
                    state_s = ST_DONE;
                end else if (accept_s) begin
                    state_s = is_multi_s ? ST_BUSY : ST_DONE;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Datapath registers: result, HI/LO, and multiply/divide working state.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_r   <= {SHW{1'b0}};
            work_r  <= {(2*WIDTH){1'b0}};
            mag_b_r <= ZERO_W;
            a_r     <= ZERO_W;
            mdiv_r  <= 1'b0;
            neg_q_r <= 1'b0;
            neg_r_r <= 1'b0;
            dz_r    <= 1'b0;
            y_r     <= ZERO_W;
            zero_r  <= 1'b1;
            hi_r    <= ZERO_W;
            lo_r    <= ZERO_W;
        end else if (state_r == ST_BUSY) begin
            work_r <= next_work_s;
            if (last_s) begin
                cnt_r  <= {SHW{1'b0}};
                hi_r   <= fin_hi_s;
                lo_r   <= fin_lo_s;
                y_r    <= fin_lo_s;
                zero_r <= (fin_lo_s == ZERO_W);
            end else begin
                cnt_r <= cnt_r + CNT_ONE;
            end
        end else if (accept_s) begin
            if (is_multi_s) begin
                // Both algorithms start from {0, |a|} with |b| as the second operand.
                cnt_r   <= {SHW{1'b0}};
                work_r  <= {ZERO_W, mag_a_s};
                mag_b_r <= mag_b_s;
                a_r     <= a;
                mdiv_r  <= op[1];
                neg_q_r <= signed_op_s && (a[WIDTH-1] ^ b[WIDTH-1]);
                neg_r_r <= signed_op_s && a[WIDTH-1];
                dz_r    <= (b == ZERO_W);
            end else begin
                y_r    <= alu_s;
                zero_r <= (alu_s == ZERO_W);
                if (op == 5'b10010) begin
                    hi_r <= a;
                end
                if (op == 5'b10011) begin
                    lo_r <= a;
                end
            end
        end
    end

endmodule
